// File: rtl/led_bar_pio.sv
// led_bar_pio
//   Avalon-MM slave LED port for the audio visualizer. Software either drives
//   a direct LED pattern (with atomic set/clear) or writes audio levels. A
//   bar-graph engine then animates them with instant attack, timed decay and
//   a held peak marker. A global 8-bit PWM dims the whole output.
//
// Parameters
//   WIDTH      number of LEDs (1..32)
//   DECAY_DIV  clk cycles per decay tick (>=2)
//   PEAK_HOLD  decay ticks the peak marker is held before it falls (0..255)
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word register index (0 DATA, 1 CTRL, 2 LEVEL, 3 PEAK,
//               4 OUTSET, 5 OUTCLEAR)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    combinational read data, zero latency
//   out_port    registered LED drive
module led_bar_pio #(
  parameter int WIDTH     = 18,
  parameter int DECAY_DIV = 500000,
  parameter int PEAK_HOLD = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int              PW         = $clog2(DECAY_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DECAY_DIV - 1);
  localparam logic [5:0]      LEVEL_MAX  = 6'(WIDTH);
  localparam logic [7:0]      HOLD_INIT  = 8'(PEAK_HOLD);

  logic [WIDTH-1:0] data_reg;
  logic             mode;
  logic             peak_en;
  logic [7:0]       brightness;
  logic [5:0]       target;
  logic [5:0]       bar_level;
  logic [5:0]       peak;
  logic [7:0]       hold;
  logic [PW-1:0]    presc;
  logic [7:0]       pwm_cnt;

  logic             wr;
  logic             tick;
  logic             level_wr;
  logic [5:0]       lvl_wdata;
  logic [5:0]       bar_next;
  logic             pwm_on;
  logic [WIDTH-1:0] pattern;

  assign wr       = chipselect && !write_n;
  assign tick     = (presc == PRESC_LAST);
  assign level_wr = wr && (address == 3'd2);
  assign pwm_on   = (brightness == 8'hFF) || (pwm_cnt < brightness);

  // Clamp on the full 32-bit value so large writes saturate instead of
  // wrapping through the 6-bit field.
  always_comb begin
    lvl_wdata = writedata[5:0];
    if (writedata > 32'(WIDTH)) lvl_wdata = LEVEL_MAX;
  end

  // A LEVEL write owns the cycle: no decay step is taken even on a tick.
  always_comb begin
    bar_next = bar_level;
    if (level_wr) begin
      if (lvl_wdata > bar_level) bar_next = lvl_wdata;
    end else if (tick && (bar_level > target)) begin
      bar_next = bar_level - 6'd1;
    end
  end

  always_comb begin
    pattern = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mode) pattern[i] = (6'(i) < bar_level);
      else      pattern[i] = data_reg[i];
      if (peak_en && (peak != 6'd0) && (6'(i) == peak - 6'd1)) pattern[i] = 1'b1;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata = 32'(data_reg);
      3'd1:    readdata = {16'h0, brightness, 6'h0, peak_en, mode};
      3'd2:    readdata = {26'h0, bar_level};
      3'd3:    readdata = {26'h0, peak};
      default: readdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg   <= '0;
      mode       <= 1'b0;
      peak_en    <= 1'b0;
      brightness <= 8'hFF;
    end else if (wr) begin
      case (address)
        3'd0: data_reg <= writedata[WIDTH-1:0];
        3'd1: begin
          mode       <= writedata[0];
          peak_en    <= writedata[1];
          brightness <= writedata[15:8];
        end
        3'd4: data_reg <= data_reg | writedata[WIDTH-1:0];
        3'd5: data_reg <= data_reg & ~writedata[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= '0;
      pwm_cnt <= 8'd0;
    end else begin
      presc   <= tick ? '0 : presc + PW'(1);
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Peak compares against the pre-update bar_level when falling, so it can
  // never drop below the bar even when both move on the same tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target    <= 6'd0;
      bar_level <= 6'd0;
      peak      <= 6'd0;
      hold      <= 8'd0;
    end else begin
      if (level_wr) target <= lvl_wdata;
      bar_level <= bar_next;
      if (bar_next > peak) begin
        peak <= bar_next;
        hold <= HOLD_INIT;
      end else if (tick) begin
        if (hold != 8'd0)           hold <= hold - 8'd1;
        else if (peak > bar_level)  peak <= peak - 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= '0;
    else          out_port <= pattern & {WIDTH{pwm_on}};
  end

endmodule

// File: tb/tb_led_bar_pio.sv
// tb_led_bar_pio
//   Directed bench for led_bar_pio with WIDTH=18, DECAY_DIV=4, PEAK_HOLD=2.
//   Tick edges are located by counting clk edges since reset release: the
//   n-th tick is sampled on edge 4n.
module tb_led_bar_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [17:0] out_port;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;

  led_bar_pio #(.WIDTH(18), .DECAY_DIV(4), .PEAK_HOLD(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = readdata;
  endtask

  task automatic idle_until(input int n);
    while (ecnt < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("out_in_reset", 32'(out_port), 32'h0);
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] bar_out(input int bar, input int pk);
    logic [31:0] m;
    m = (32'd1 << bar) - 32'd1;
    if (pk > 0) m = m | (32'd1 << (pk - 1));
    return m;
  endfunction

  initial begin
    logic [31:0] v;
    int ones;
    int full;
    int exp_bar;
    int exp_pk;

    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;

    // reset values and direct write latency
    do_reset();
    bus_rd(3'd1, v); check("ctrl_reset", v, 32'h0000FF00);
    bus_rd(3'd0, v); check("data_reset", v, 32'h0);
    bus_rd(3'd2, v); check("level_reset", v, 32'h0);
    bus_wr(3'd0, 32'h3FFFF);
    check("out_1edge", 32'(out_port), 32'h0);
    @(posedge clk); #1;
    check("out_2edge", 32'(out_port), 32'h3FFFF);
    bus_rd(3'd0, v); check("data_rd", v, 32'h3FFFF);

    // atomic set / clear
    bus_wr(3'd0, 32'h000F0);
    bus_wr(3'd4, 32'h00003);
    bus_wr(3'd5, 32'h00010);
    bus_rd(3'd0, v); check("data_setclr", v, 32'h000E3);
    bus_rd(3'd4, v); check("outset_rd", v, 32'h0);
    bus_rd(3'd5, v); check("outclr_rd", v, 32'h0);
    @(posedge clk); #1;
    check("out_setclr", 32'(out_port), 32'h000E3);
    bus_rd(3'd6, v); check("addr6_rd", v, 32'h0);
    bus_rd(3'd7, v); check("addr7_rd", v, 32'h0);
    bus_wr(3'd3, 32'h5);
    bus_rd(3'd3, v); check("peak_wr_ignored", v, 32'h0);

    // bar mode, brightness 1, clamped level
    bus_wr(3'd1, 32'h00000101);
    bus_wr(3'd2, 32'd40);
    bus_rd(3'd2, v); check("level_clamp", v, 32'd18);
    bus_rd(3'd3, v); check("peak_clamp", v, 32'd18);
    bus_rd(3'd1, v); check("ctrl_rd", v, 32'h00000101);
    repeat (2) @(posedge clk);
    #1;
    ones = 0;
    full = 0;
    for (int i = 0; i < 512; i++) begin
      if (out_port != 18'h0)     ones++;
      if (out_port == 18'h3FFFF) full++;
      @(posedge clk); #1;
    end
    check("pwm_lit_cycles", 32'(ones), 32'd2);
    check("pwm_full_cycles", 32'(full), 32'd2);

    // decay with peak hold
    do_reset();
    bus_wr(3'd1, 32'h0000FF03);
    bus_wr(3'd2, 32'd10);
    bus_wr(3'd2, 32'd0);
    bus_rd(3'd2, v); check("decay_start_level", v, 32'd10);
    bus_rd(3'd3, v); check("decay_start_peak", v, 32'd10);
    @(posedge clk); #1;
    check("decay_start_out", 32'(out_port), 32'h003FF);
    for (int k = 1; k <= 12; k++) begin
      exp_bar = (k < 10) ? 10 - k : 0;
      exp_pk  = (k <= 2) ? 10 : ((12 - k > 0) ? 12 - k : 0);
      idle_until(4 * k);
      bus_rd(3'd2, v); check($sformatf("decay_level_t%0d", k), v, 32'(exp_bar));
      bus_rd(3'd3, v); check($sformatf("decay_peak_t%0d", k), v, 32'(exp_pk));
      @(posedge clk); #1;
      check($sformatf("decay_out_t%0d", k), 32'(out_port), bar_out(exp_bar, exp_pk));
    end

    // LEVEL write coinciding with a tick
    do_reset();
    bus_wr(3'd2, 32'd5);
    bus_wr(3'd2, 32'd2);
    idle_until(3);
    bus_wr(3'd2, 32'd3);
    bus_rd(3'd2, v); check("tick_wr_level", v, 32'd5);
    idle_until(8);
    bus_rd(3'd2, v); check("tick_wr_decay1", v, 32'd4);
    idle_until(12);
    bus_rd(3'd2, v); check("tick_wr_decay2", v, 32'd3);
    idle_until(20);
    bus_rd(3'd2, v); check("tick_wr_floor", v, 32'd3);

    // reset mid-decay
    do_reset();
    bus_wr(3'd1, 32'h0000FF03);
    bus_wr(3'd2, 32'd10);
    bus_wr(3'd2, 32'd0);
    idle_until(13);
    bus_rd(3'd2, v); check("pre_rst_level", v, 32'd7);
    check("pre_rst_out", 32'(out_port), 32'h0017F);
    reset_n = 1'b0;
    #1;
    check("rst_out", 32'(out_port), 32'h0);
    bus_rd(3'd2, v); check("rst_level", v, 32'h0);
    bus_rd(3'd3, v); check("rst_peak", v, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus_rd(3'd1, v); check("rst_ctrl", v, 32'h0000FF00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
